multi_mode_freq_sweeper: RTL
============================

Name: multi_mode_freq_sweeper

Overview:
Parametrised successor to the single-mode sweeper/PLL controller. It accepts instructions over a valid/ready handshake and runs one of three modes: up-sweep, up-down (triangle) sweep, or PLL lock/track. In PLL mode it uses shift-based PI gains with integrator saturation and a lock indicator. Sits between the instruction FIFO and the DDS tuning-word input, and takes phase error from the phase detector.

Parameters:
FREQ_W, 32, DDS tuning-word width; freq_step is signed FREQ_W.
CYC_W, 16, dwell-count field width.
STEP_W, 12, step-count field width.
PHASE_W, 16, signed phase-error width.
KP_SHIFT, 13, proportional gain = 2^KP_SHIFT.
KI_SHIFT, 12, integral gain = 2^KI_SHIFT.
INT_LIMIT, 2^28, integrator saturation magnitude; the integrator is clamped to ±INT_LIMIT.
LOCK_CYCLES, 1024, settle clocks spent in PLL_LOCK.
TRACK_PERIOD, 16, clocks between PI updates.
LOCK_TOL, 64, |phase_error| threshold for the lock count.
Derived, not overridable: INSTR_W = 2+STEP_W+CYC_W+2*FREQ_W (94 at defaults).

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
instr_data  in  INSTR_W  {mode[1:0], num_steps, cycles_per_step, init_freq, freq_step}, MSB first
instr_valid  in  1  instruction available
instr_ready  out  1  block can accept an instruction
abort  in  1  stop the current operation
phase_error  in  PHASE_W  signed phase error
dds_freq  out  FREQ_W  tuning word
sweep_start  out  1  one-cycle pulse when a sweep begins
sweep_done  out  1  one-cycle pulse when a sweep completes
pll_enable  out  1  high in PLL_LOCK and PLL_TRACK
pll_locked  out  1  lock indicator
busy  out  1  state != IDLE
cmd_error  out  1  one-cycle pulse on a reserved mode
aborted  out  1  one-cycle pulse on abort

Behaviour:
- Reset values: all outputs 0, except instr_ready = 1. State = IDLE; integrator = 0.
- States: IDLE, SWEEP, PLL_LOCK, PLL_TRACK.
- instr_ready = (state == IDLE) && !abort. An instruction is accepted when instr_valid && instr_ready.
- Field decode on accept:
  - mode 00: SWEEP, up.
  - mode 01: SWEEP, up-down.
  - mode 10: PLL_LOCK.
  - mode 11: reserved. cmd_error pulses next cycle, the instruction is consumed, state stays IDLE, dds_freq is unchanged.
- Accept latency: the cycle after acceptance, dds_freq = init_freq and busy = 1. In sweep modes sweep_start pulses in that same cycle.
- Dwell: each frequency is held D = max(cycles_per_step, 1) clocks, with the dwell counter reset on every frequency change.
- Up sweep:
  - Outputs init_freq + k*freq_step for k = 0..num_steps, i.e. num_steps+1 frequencies.
  - After the last dwell, sweep_done pulses for one cycle and state returns to IDLE.
  - dds_freq holds the final value in IDLE.
- Up-down sweep: after the up phase reaches k = num_steps, it steps back down to k = 0 and then completes. Total frequencies = 2*num_steps+1, each held D clocks.
- num_steps = 0: init_freq is held D clocks, then done (both sweep modes).
- Arithmetic: all frequency arithmetic is modulo 2^FREQ_W, with no saturation. A negative freq_step therefore gives a down-sweep.
- PLL_LOCK:
  - pll_enable = 1 and dds_freq = init_freq.
  - After LOCK_CYCLES clocks, go to PLL_TRACK; the integrator is already 0.
- PLL_TRACK update (every TRACK_PERIOD clocks; first update TRACK_PERIOD clocks after entry):
  - e = sign-extended phase_error.
  - integ_next = clamp(integ + (e <<< KI_SHIFT), ±INT_LIMIT), computed at FREQ_W+2 bits before the clamp.
  - dds_freq = init_freq + (e <<< KP_SHIFT) + integ_next (mod 2^FREQ_W), registered one cycle after the update strobe.
- Lock indicator: each update with |e| <= LOCK_TOL increments a 3-bit saturating counter; pll_locked = (counter == 7). Any update with |e| > LOCK_TOL clears the counter and pll_locked.
- PLL mode has no natural end; it runs until abort.
- Abort (any non-IDLE state): next cycle state = IDLE and aborted pulses. sweep_done is not pulsed. pll_enable, pll_locked and the lock counter are cleared, the integrator is cleared, and dds_freq holds its last value.
- Abort coincidences:
  - Abort in IDLE: no effect, no aborted pulse.
  - Abort in the same cycle as instr_valid in IDLE: no accept, because instr_ready is low.
  - Abort in the same cycle as the final dwell clock: the abort wins and sweep_done is not pulsed.
- Asynchronous reset mid-operation returns every output to its reset value immediately.

Test Plan:
- mode 00, init=1000, step=10, steps=3, cyc=2 -> dds_freq 1000, 1010, 1020, 1030, each held 2 clocks; sweep_start 1 clk after accept; sweep_done once after 8 clocks.
- mode 01, init=0, step=5, steps=2, cyc=1 -> sequence 0, 5, 10, 5, 0, then sweep_done; mode 00 with init=0xFFFFFFF0, step=0x20, steps=1 -> 0x00000010 (wrap).
- mode 11 -> cmd_error pulse, busy stays 0, dds_freq unchanged, next instruction accepted normally.
- mode 10, init=0x40000000, phase_error=+1 constant -> after 1024 + 16 clocks dds_freq = 0x40000000 + 0x2000 + 0x1000. pll_locked rises on the 7th update. Integrator stops at +2^28 after enough updates.
- PLL tracking, then phase_error = 1000 for one update -> pll_locked drops; abort -> aborted pulse, pll_enable 0, dds_freq held, instr_ready 1 next cycle.
- Reset asserted mid-sweep -> all outputs 0 and instr_ready 1 asynchronously; sweep resumes only on a new instruction.

Source files
------------

// File: rtl/multi_mode_freq_sweeper.sv
// Multi-mode DDS frequency controller: up sweep, up-down (triangle) sweep,
// or PLL lock/track with shift-based PI gains, integrator clamp and lock flag.
// Instructions arrive over a valid/ready handshake; abort returns to IDLE.
module multi_mode_freq_sweeper #(
  parameter  int FREQ_W       = 32,
  parameter  int CYC_W        = 16,
  parameter  int STEP_W       = 12,
  parameter  int PHASE_W      = 16,
  parameter  int KP_SHIFT     = 13,
  parameter  int KI_SHIFT     = 12,
  parameter  int INT_LIMIT    = 268435456,
  parameter  int LOCK_CYCLES  = 1024,
  parameter  int TRACK_PERIOD = 16,
  parameter  int LOCK_TOL     = 64,
  localparam int INSTR_W      = 2 + STEP_W + CYC_W + 2 * FREQ_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [INSTR_W-1:0]        instr_data,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic                      abort,
  input  logic signed [PHASE_W-1:0] phase_error,
  output logic [FREQ_W-1:0]         dds_freq,
  output logic                      sweep_start,
  output logic                      sweep_done,
  output logic                      pll_enable,
  output logic                      pll_locked,
  output logic                      busy,
  output logic                      cmd_error,
  output logic                      aborted
);

  // Integrator and sign-extended error are kept two bits wider than the
  // tuning word so the sum cannot wrap before the clamp is applied.
  localparam int IW = FREQ_W + 2;
  localparam logic signed [IW-1:0] LIM_POS = IW'(INT_LIMIT);
  localparam logic signed [IW-1:0] LIM_NEG = -LIM_POS;
  localparam logic signed [IW-1:0] TOL     = IW'(LOCK_TOL);

  typedef enum logic [1:0] {IDLE, SWEEP, PLL_LOCK, PLL_TRACK} state_t;

  state_t                  state_q, state_d;
  logic [FREQ_W-1:0]       dds_q, dds_d, init_q, init_d, step_q, step_d;
  logic [STEP_W-1:0]       nsteps_q, nsteps_d, k_q, k_d;
  logic [CYC_W-1:0]        dwell_q, dwell_d, cnt_q, cnt_d;
  logic                    down_q, down_d, updown_q, updown_d;
  logic [31:0]             timer_q, timer_d;
  logic signed [IW-1:0]    integ_q, integ_d;
  logic [2:0]              lcnt_q, lcnt_d;
  logic                    locked_q, locked_d, start_q, start_d, done_q, done_d;
  logic                    cerr_q, cerr_d, abt_q, abt_d, busy_q, busy_d, pen_q, pen_d;

  logic                    accept;
  logic [1:0]              f_mode;
  logic [STEP_W-1:0]       f_nsteps;
  logic [CYC_W-1:0]        f_cyc;
  logic [FREQ_W-1:0]       f_init, f_step, e_w, kp_term, pll_freq;
  logic signed [IW-1:0]    e_ext, e_abs, integ_sum, integ_sat;
  logic                    e_small;

  assign instr_ready = (state_q == IDLE) && !abort;
  assign accept      = instr_valid && instr_ready;

  assign f_mode   = instr_data[INSTR_W-1 -: 2];
  assign f_nsteps = instr_data[INSTR_W-3 -: STEP_W];
  assign f_cyc    = instr_data[2*FREQ_W+CYC_W-1 -: CYC_W];
  assign f_init   = instr_data[2*FREQ_W-1 -: FREQ_W];
  assign f_step   = instr_data[FREQ_W-1:0];

  // PI datapath: sign extension, integrator clamp, new tuning word, lock test.
  always_comb begin
    e_ext     = {{(IW-PHASE_W){phase_error[PHASE_W-1]}}, phase_error};
    e_w       = e_ext[FREQ_W-1:0];
    kp_term   = e_w << KP_SHIFT;
    integ_sum = integ_q + (e_ext <<< KI_SHIFT);
    if (integ_sum > LIM_POS) begin
      integ_sat = LIM_POS;
    end else if (integ_sum < LIM_NEG) begin
      integ_sat = LIM_NEG;
    end else begin
      integ_sat = integ_sum;
    end
    pll_freq = init_q + kp_term + integ_sat[FREQ_W-1:0];
    e_abs    = e_ext[IW-1] ? -e_ext : e_ext;
    e_small  = (e_abs <= TOL);
  end

  // Next-state and output decode for all modes; abort overrides any activity.
  always_comb begin
    state_d  = state_q;   dds_d    = dds_q;    init_d  = init_q;  step_d = step_q;
    nsteps_d = nsteps_q;  k_d      = k_q;      dwell_d = dwell_q; cnt_d  = cnt_q;
    down_d   = down_q;    updown_d = updown_q; timer_d = timer_q; integ_d = integ_q;
    lcnt_d   = lcnt_q;    locked_d = locked_q;
    start_d  = 1'b0;      done_d   = 1'b0;     cerr_d  = 1'b0;    abt_d  = 1'b0;
    if ((state_q != IDLE) && abort) begin
      state_d  = IDLE;
      abt_d    = 1'b1;
      integ_d  = {IW{1'b0}};
      lcnt_d   = 3'd0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (f_mode)
              2'b00, 2'b01: begin
                state_d  = SWEEP;
                dds_d    = f_init;
                step_d   = f_step;
                nsteps_d = f_nsteps;
                dwell_d  = (f_cyc == {CYC_W{1'b0}}) ? {{(CYC_W-1){1'b0}}, 1'b1} : f_cyc;
                cnt_d    = {CYC_W{1'b0}};
                k_d      = {STEP_W{1'b0}};
                down_d   = 1'b0;
                updown_d = f_mode[0];
                start_d  = 1'b1;
              end
              2'b10: begin
                state_d  = PLL_LOCK;
                dds_d    = f_init;
                init_d   = f_init;
                timer_d  = 32'd0;
                integ_d  = {IW{1'b0}};
                lcnt_d   = 3'd0;
                locked_d = 1'b0;
              end
              default: cerr_d = 1'b1;
            endcase
          end else begin
            state_d = IDLE;
          end
        end
        SWEEP: begin
          if (cnt_q != dwell_q - {{(CYC_W-1){1'b0}}, 1'b1}) begin
            cnt_d = cnt_q + {{(CYC_W-1){1'b0}}, 1'b1};
          end else if (!down_q) begin
            if (k_q != nsteps_q) begin
              k_d   = k_q + {{(STEP_W-1){1'b0}}, 1'b1};
              dds_d = dds_q + step_q;
              cnt_d = {CYC_W{1'b0}};
            end else if (updown_q && (nsteps_q != {STEP_W{1'b0}})) begin
              down_d = 1'b1;
              k_d    = k_q - {{(STEP_W-1){1'b0}}, 1'b1};
              dds_d  = dds_q - step_q;
              cnt_d  = {CYC_W{1'b0}};
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            if (k_q != {STEP_W{1'b0}}) begin
              k_d   = k_q - {{(STEP_W-1){1'b0}}, 1'b1};
              dds_d = dds_q - step_q;
              cnt_d = {CYC_W{1'b0}};
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        PLL_LOCK: begin
          if (timer_q == 32'(LOCK_CYCLES - 1)) begin
            state_d = PLL_TRACK;
            timer_d = 32'd0;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        PLL_TRACK: begin
          if (timer_q == 32'(TRACK_PERIOD - 1)) begin
            timer_d = 32'd0;
            integ_d = integ_sat;
            dds_d   = pll_freq;
            if (e_small) begin
              lcnt_d = (lcnt_q == 3'd7) ? 3'd7 : lcnt_q + 3'd1;
            end else begin
              lcnt_d = 3'd0;
            end
            locked_d = e_small && (lcnt_q >= 3'd6);
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
    pen_d  = (state_d == PLL_LOCK) || (state_d == PLL_TRACK);
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;               dds_q    <= {FREQ_W{1'b0}};
      init_q   <= {FREQ_W{1'b0}};     step_q   <= {FREQ_W{1'b0}};
      nsteps_q <= {STEP_W{1'b0}};     k_q      <= {STEP_W{1'b0}};
      dwell_q  <= {CYC_W{1'b0}};      cnt_q    <= {CYC_W{1'b0}};
      down_q   <= 1'b0;               updown_q <= 1'b0;
      timer_q  <= 32'd0;              integ_q  <= {IW{1'b0}};
      lcnt_q   <= 3'd0;               locked_q <= 1'b0;
      start_q  <= 1'b0;               done_q   <= 1'b0;
      cerr_q   <= 1'b0;               abt_q    <= 1'b0;
      busy_q   <= 1'b0;               pen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;            dds_q    <= dds_d;
      init_q   <= init_d;             step_q   <= step_d;
      nsteps_q <= nsteps_d;           k_q      <= k_d;
      dwell_q  <= dwell_d;            cnt_q    <= cnt_d;
      down_q   <= down_d;             updown_q <= updown_d;
      timer_q  <= timer_d;            integ_q  <= integ_d;
      lcnt_q   <= lcnt_d;             locked_q <= locked_d;
      start_q  <= start_d;            done_q   <= done_d;
      cerr_q   <= cerr_d;             abt_q    <= abt_d;
      busy_q   <= busy_d;             pen_q    <= pen_d;
    end
  end

  assign dds_freq    = dds_q;
  assign sweep_start = start_q;
  assign sweep_done  = done_q;
  assign pll_enable  = pen_q;
  assign pll_locked  = locked_q;
  assign busy        = busy_q;
  assign cmd_error   = cerr_q;
  assign aborted     = abt_q;

endmodule
